// File: rtl/ft_reg_bridge.sv
// ----------------------------------------------------------------------------
// ft_reg_bridge
// Bridges a word-oriented FWFT command stream onto a simple register bus and
// returns read data on a push-style downstream stream.
//
// A command is a header word ([15:12] opcode: 1 = write, 2 = read; [11:0] N),
// then an address word, then N data words for a write. A read echoes the
// header downstream, then returns N register words at consecutive addresses.
// Addresses wrap modulo 2^ADDR_WIDTH.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rx_data/valid/en  upstream FWFT source: [17:16] byte enables, [15:0] data
//   tx_data/en/full   downstream sink: push tx_data when tx_en, stall on full
//   reg_addr          register address (current command address)
//   reg_wr/_wr_data   one-cycle write strobe with data
//   reg_rd/_rd_data   one-cycle read strobe; read data valid one cycle later
//   busy              high whenever a command is in progress
//   err_cnt           saturating count of protocol errors
//
// Strobes (rx_en, reg_wr, reg_rd, tx_en) are decoded from the registered state
// in the same cycle the word is consumed or sent, so that a reset drops them
// immediately. rx_en is also gated by rst so nothing is popped during reset.
// ----------------------------------------------------------------------------
module ft_reg_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_en,
  input  logic                  tx_full,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_RHDR   = 3'd3,
    S_RISSUE = 3'd4,
    S_RWAIT  = 3'd5,
    S_RSEND  = 3'd6
  } state_t;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hdr_q, hdr_d;
  logic [11:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [7:0]              err_q, err_d;

  logic                    be_ok_s;
  logic                    err_inc_s;
  logic [DATA_WIDTH-1:0]   word_s;
  logic [3:0]              op_s;
  logic [11:0]             n_s;

  assign word_s   = rx_data[DATA_WIDTH-1:0];
  assign be_ok_s  = (rx_data[DATA_WIDTH+1:DATA_WIDTH] == 2'b11);
  assign op_s     = word_s[15:12];
  assign n_s      = word_s[11:0];
  assign reg_addr = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign err_cnt  = err_q;

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    err_inc_s   = 1'b0;
    reg_wr      = 1'b0;
    reg_wr_data = {DATA_WIDTH{1'b0}};
    reg_rd      = 1'b0;
    tx_en       = 1'b0;
    tx_data     = {DATA_WIDTH{1'b0}};
    rx_en       = rx_valid && !rst &&
                  ((state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA));

    case (state_q)
      S_IDLE: begin
        if (rx_en) begin
          if (!be_ok_s) begin
            err_inc_s = 1'b1;
          end else if ((op_s == OP_WRITE) || (op_s == OP_READ)) begin
            // N = 0 is a legal no-op: stay idle without flagging an error.
            if (n_s != 12'd0) begin
              hdr_d   = word_s;
              cnt_d   = n_s;
              state_d = S_ADDR;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            err_inc_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rx_en) begin
          if (!be_ok_s) begin
            err_inc_s = 1'b1;
            state_d   = S_IDLE;
          end else begin
            addr_d  = word_s[ADDR_WIDTH-1:0];
            state_d = (hdr_q[15:12] == OP_WRITE) ? S_WDATA : S_RHDR;
          end
        end else begin
          state_d = S_ADDR;
        end
      end
      S_WDATA: begin
        if (rx_en) begin
          if (!be_ok_s) begin
            err_inc_s = 1'b1;
            state_d   = S_IDLE;
          end else begin
            reg_wr      = 1'b1;
            reg_wr_data = word_s;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            cnt_d       = cnt_q - 12'd1;
            state_d     = (cnt_q == 12'd1) ? S_IDLE : S_WDATA;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RHDR: begin
        if (!tx_full) begin
          tx_en   = 1'b1;
          tx_data = hdr_q;
          state_d = S_RISSUE;
        end else begin
          state_d = S_RHDR;
        end
      end
      S_RISSUE: begin
        reg_rd  = 1'b1;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        // Read data is only valid for this one cycle, so no stall here.
        hold_d  = reg_rd_data;
        state_d = S_RSEND;
      end
      S_RSEND: begin
        if (!tx_full) begin
          tx_en   = 1'b1;
          tx_data = hold_q;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q - 12'd1;
          state_d = (cnt_q == 12'd1) ? S_IDLE : S_RISSUE;
        end else begin
          state_d = S_RSEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (err_inc_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q   <= {DATA_WIDTH{1'b0}};
      cnt_q   <= 12'd0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      hold_q  <= {DATA_WIDTH{1'b0}};
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule
